// File: rtl/grf_scoreboard.sv
// General register file with NUM_RD combinational read ports, optional write-to-read
// bypass, and a per-register pending-write scoreboard for the hazard unit.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int TRACE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [31:0]              wr_pc,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;

    assign wr_ok = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Release first, then a reservation overrides a release of the same register,
    // and flush overrides everything. Releases of other registers are never lost.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;

        assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
        assign byp = (BYPASS != 0) && wr_ok && (wr_addr == ra);

        assign rd_data[i*DATA_W +: DATA_W] = reset ? '0 : (byp ? wr_data : regs[ra]);
        assign rd_busy[i]                  = reset ? 1'b0 : (busy[ra] & ~byp);
    end

`ifndef SYNTHESIS
    // Commit trace includes $0 writes so the log lines up with the ISA model.
    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset && wr_en) begin
                $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: a bypassing instance and a non-bypassing instance
// share stimulus; expected values are queued as stimulus is driven and popped at each check.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .TRACE(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .TRACE(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_pc    = 32'h0000_1000;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;

        // Reset state
        set_rd(5'd5, 5'd7);
        expect_val("reset_data", 64'h0);
        expect_val("reset_busy", 64'h0);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});
        tick();
        tick();
        reset = 1'b0;

        // 1: write $5 = 0x1234 while reserving it, then async reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; wr_pc = 32'h0000_1004;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle_inputs();
        set_rd(5'd5, 5'd5);
        expect_val("t1_data", {32'h1234, 32'h1234});
        expect_val("t1_busy", 64'h3);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});
        #1;
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA_5555;
        expect_val("t1_rst_data", 64'h0);
        expect_val("t1_rst_busy", 64'h0);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});
        tick();
        idle_inputs();
        reset = 1'b0;
        expect_val("t1_after_rst", 64'h0);
        #1;
        check(rd_data);

        // 2: write and reserve $0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_pc = 32'h0000_1008;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        expect_val("t2_bypass_r0", 64'h0);
        #1;
        check(rd_data);
        tick();
        idle_inputs();
        expect_val("t2_data_r0", 64'h0);
        expect_val("t2_busy_r0", 64'h0);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});

        // 3: bypass of $7 on both ports, old value without bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777; wr_pc = 32'h0000_100C;
        tick();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle_inputs();
        set_rd(5'd7, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; wr_pc = 32'h0000_1010;
        expect_val("t3_byp_data", {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        expect_val("t3_byp_busy", 64'h0);
        expect_val("t3_nb_data", {32'h7777, 32'h7777});
        expect_val("t3_nb_busy", 64'h3);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});
        check(rd_data_nb);
        check({62'h0, rd_busy_nb});
        tick();
        idle_inputs();
        expect_val("t3_nb_next_data", {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        expect_val("t3_nb_next_busy", 64'h0);
        #1;
        check(rd_data_nb);
        check({62'h0, rd_busy_nb});

        // 4: reserve $3, idle twice, then release with 0x42
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        idle_inputs();
        tick();
        tick();
        set_rd(5'd3, 5'd3);
        expect_val("t4_busy", 64'h3);
        #1;
        check({62'h0, rd_busy});
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h42; wr_pc = 32'h0000_1014;
        expect_val("t4_nb_busy_wr", 64'h3);
        expect_val("t4_byp_busy_wr", 64'h0);
        #1;
        check({62'h0, rd_busy_nb});
        check({62'h0, rd_busy});
        tick();
        idle_inputs();
        expect_val("t4_busy_clr", 64'h0);
        expect_val("t4_nb_busy_clr", 64'h0);
        expect_val("t4_data", {32'h42, 32'h42});
        expect_val("t4_nb_data", {32'h42, 32'h42});
        #1;
        check({62'h0, rd_busy});
        check({62'h0, rd_busy_nb});
        check(rd_data);
        check(rd_data_nb);

        // 5: reserve and write $9 in the same cycle
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11; wr_pc = 32'h0000_1018;
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd9);
        expect_val("t5_data", {32'h11, 32'h11});
        expect_val("t5_busy", 64'h3);
        #1;
        check(rd_data);
        check({62'h0, rd_busy});

        // 6: reserve $1, $2, $4 then flush alongside a write of $2
        rsv_en = 1'b1; rsv_addr = 5'd1;
        tick();
        rsv_addr = 5'd2;
        tick();
        rsv_addr = 5'd4;
        tick();
        idle_inputs();
        set_rd(5'd1, 5'd4);
        expect_val("t6_pre_busy", 64'h3);
        #1;
        check({62'h0, rd_busy});
        flush = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55; wr_pc = 32'h0000_101C;
        tick();
        idle_inputs();
        expect_val("t6_busy_14", 64'h0);
        #1;
        check({62'h0, rd_busy});
        set_rd(5'd2, 5'd9);
        expect_val("t6_busy_2_9", 64'h0);
        expect_val("t6_data", {32'h11, 32'h55});
        #1;
        check({62'h0, rd_busy});
        check(rd_data);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries remain, 0 expected", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
